// File: rtl/fpu_exception_collector_pkg.sv
// Shared definitions for the FPU exception path: flag bit positions,
// collector state encoding and the 8087 pre-operation priority filter.
package fpu_exception_collector_pkg;

    localparam int EXC_INV  = 0;
    localparam int EXC_DEN  = 1;
    localparam int EXC_ZDIV = 2;
    localparam int EXC_OVF  = 3;
    localparam int EXC_UNF  = 4;
    localparam int EXC_PREC = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_POST  = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0] exc;
        logic       suppress;
    } filt_t;

    // An unmasked pre-operation exception (invalid, then zero-divide, then
    // denormal) pre-empts everything else and cancels the result store.
    // Masked flags are reported as-is and never cancel the store.
    function automatic filt_t exc_filter(input logic [5:0] acc, input logic [5:0] mask);
        logic [5:0] u;
        filt_t      f;
        u          = acc & ~mask;
        f.exc      = acc;
        f.suppress = 1'b0;
        if (u[EXC_INV]) begin
            f.exc           = '0;
            f.exc[EXC_INV]  = 1'b1;
            f.suppress      = 1'b1;
        end else if (u[EXC_ZDIV]) begin
            f.exc           = '0;
            f.exc[EXC_ZDIV] = 1'b1;
            f.suppress      = 1'b1;
        end else if (u[EXC_DEN]) begin
            f.exc           = '0;
            f.exc[EXC_DEN]  = 1'b1;
            f.suppress      = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/fpu_exception_collector.sv
// Collects exception flags over the life of one FPU instruction and posts a
// single filtered exception set with a one-cycle latch strobe. A watchdog
// turns a never-completing instruction into an invalid-operation post.
module fpu_exception_collector
    import fpu_exception_collector_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_start,
    input  logic       op_done,
    input  logic       op_abort,
    input  logic       flag_valid,
    input  logic [5:0] flag_vec,
    input  logic [5:0] mask_vec,
    output logic       exception_invalid,
    output logic       exception_denormal,
    output logic       exception_zero_div,
    output logic       exception_overflow,
    output logic       exception_underflow,
    output logic       exception_precision,
    output logic       exception_latch,
    output logic       suppress_writeback,
    output logic       timeout_pulse,
    output logic       busy,
    output logic       proto_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t           r_state;
    logic [5:0]       r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_exc;
    logic             r_latch;
    logic             r_suppress;
    logic             r_timeout;
    logic             r_busy;
    logic             r_proto;

    logic [5:0]       w_flags;
    logic [5:0]       w_acc_merged;
    logic             w_cnt_expired;
    filt_t            w_filt_single;
    filt_t            w_filt_done;
    filt_t            w_filt_tmo;

    // Flags arriving this cycle count toward the instruction, including the
    // cycle op_done is seen, so the filter always sees the merged set.
    assign w_flags       = flag_valid ? flag_vec : 6'h00;
    assign w_acc_merged  = r_acc | w_flags;
    assign w_cnt_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_filt_single = exc_filter(w_flags, mask_vec);
    assign w_filt_done   = exc_filter(w_acc_merged, mask_vec);
    assign w_filt_tmo    = exc_filter(w_acc_merged | 6'h01, mask_vec);

    // Collector FSM with all handler-facing outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_exc      <= '0;
            r_latch    <= 1'b0;
            r_suppress <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
            r_proto    <= 1'b0;
        end else begin
            r_exc      <= '0;
            r_latch    <= 1'b0;
            r_suppress <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_POST: begin
                    if (op_start) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (op_done && (r_state == ST_IDLE)) begin
                            r_state    <= ST_POST;
                            r_acc      <= '0;
                            r_exc      <= w_filt_single.exc;
                            r_suppress <= w_filt_single.suppress;
                            r_latch    <= 1'b1;
                        end else begin
                            r_state <= ST_ACCUM;
                            r_acc   <= w_flags;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_acc   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (op_start) begin
                        r_proto <= 1'b1;
                    end
                    if (op_abort) begin
                        r_state <= ST_IDLE;
                        r_acc   <= '0;
                        r_busy  <= 1'b0;
                    end else if (op_done) begin
                        r_state    <= ST_POST;
                        r_acc      <= '0;
                        r_exc      <= w_filt_done.exc;
                        r_suppress <= w_filt_done.suppress;
                        r_latch    <= 1'b1;
                    end else if (w_cnt_expired) begin
                        r_state    <= ST_POST;
                        r_acc      <= '0;
                        r_exc      <= w_filt_tmo.exc;
                        r_suppress <= w_filt_tmo.suppress;
                        r_latch    <= 1'b1;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_acc <= w_acc_merged;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_acc   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign exception_invalid   = r_exc[EXC_INV];
    assign exception_denormal  = r_exc[EXC_DEN];
    assign exception_zero_div  = r_exc[EXC_ZDIV];
    assign exception_overflow  = r_exc[EXC_OVF];
    assign exception_underflow = r_exc[EXC_UNF];
    assign exception_precision = r_exc[EXC_PREC];
    assign exception_latch     = r_latch;
    assign suppress_writeback  = r_suppress;
    assign timeout_pulse       = r_timeout;
    assign busy                = r_busy;
    assign proto_error         = r_proto;

endmodule

// File: tb/tb_fpu_exception_collector.sv
// Directed bench for fpu_exception_collector with a transaction-level
// reference model checked every cycle plus literal expectations.
module tb_fpu_exception_collector;

    localparam int TMO = 8;

    logic       clk;
    logic       reset;
    logic       op_start, op_done, op_abort, flag_valid;
    logic [5:0] flag_vec, mask_vec;
    logic       exc_inv, exc_den, exc_zdiv, exc_ovf, exc_unf, exc_prec;
    logic       exc_latch, sup_wb, tmo_pulse, busy, proto_error;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    fpu_exception_collector #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .op_start            (op_start),
        .op_done             (op_done),
        .op_abort            (op_abort),
        .flag_valid          (flag_valid),
        .flag_vec            (flag_vec),
        .mask_vec            (mask_vec),
        .exception_invalid   (exc_inv),
        .exception_denormal  (exc_den),
        .exception_zero_div  (exc_zdiv),
        .exception_overflow  (exc_ovf),
        .exception_underflow (exc_unf),
        .exception_precision (exc_prec),
        .exception_latch     (exc_latch),
        .suppress_writeback  (sup_wb),
        .timeout_pulse       (tmo_pulse),
        .busy                (busy),
        .proto_error         (proto_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] dut_exc();
        return {exc_prec, exc_unf, exc_ovf, exc_zdiv, exc_den, exc_inv};
    endfunction

    // Reference model: tracks whether an instruction is open, how long it
    // has been open, and the union of its flags; the post is computed from
    // the priority list invalid > zero-divide > denormal.
    bit         in_flight;
    bit         posting;
    logic [5:0] m_acc;
    int         m_age;
    logic [5:0] e_exc;
    logic       e_latch, e_sup, e_tmo, e_busy, e_perr;

    function automatic logic [6:0] ref_post(input logic [5:0] raw, input logic [5:0] msk);
        int order [3];
        order = '{0, 2, 1};
        for (int k = 0; k < 3; k++) begin
            if (raw[order[k]] && !msk[order[k]]) return {1'b1, 6'(1 << order[k])};
        end
        return {1'b0, raw};
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [5:0] fl;
        logic [5:0] raw;
        logic [6:0] pr;
        bit         fire;
        bit         tmo;
        if (reset) begin
            in_flight = 0; posting = 0; m_acc = '0; m_age = 0;
            e_exc = '0; e_latch = 0; e_sup = 0; e_tmo = 0; e_busy = 0; e_perr = 0;
        end else begin
            fl   = flag_valid ? flag_vec : 6'h00;
            fire = 0; tmo = 0; raw = '0;
            if (in_flight) begin
                if (op_start) e_perr = 1;
                m_acc = m_acc | fl;
                if (op_abort) begin
                    in_flight = 0;
                end else if (op_done) begin
                    fire = 1; raw = m_acc; in_flight = 0;
                end else if (m_age + 1 >= TMO) begin
                    fire = 1; tmo = 1; raw = m_acc | 6'h01; in_flight = 0;
                end else begin
                    m_age = m_age + 1;
                end
            end else if (op_start) begin
                m_acc = fl; m_age = 0;
                if (op_done && !posting) begin
                    fire = 1; raw = fl;
                end else begin
                    in_flight = 1;
                end
            end
            posting = fire;
            pr      = ref_post(raw, mask_vec);
            e_latch = fire;
            e_tmo   = tmo;
            e_exc   = fire ? pr[5:0] : 6'h00;
            e_sup   = fire ? pr[6] : 1'b0;
            e_busy  = in_flight || posting;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [10:0] act, exp;
        if (chk_en) begin
            act = {dut_exc(), exc_latch, sup_wb, tmo_pulse, busy, proto_error};
            exp = {e_exc, e_latch, e_sup, e_tmo, e_busy, e_perr};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act, exp);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op_start = 0; op_done = 0; op_abort = 0; flag_valid = 0; flag_vec = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int  waited;
        bit  found;
        reset = 1'b1;
        idle_inputs();
        mask_vec = 6'h3F;
        #2;
        lit("reset_busy", {31'd0, busy}, 32'd0);
        lit("reset_latch", {31'd0, exc_latch}, 32'd0);
        lit("reset_exc", {26'd0, dut_exc()}, 32'd0);
        lit("reset_perr", {31'd0, proto_error}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        chk_en = 1;

        // Multi-cycle op: ovf then prec, all masked.
        mask_vec = 6'h3F;
        op_start = 1; tick();
        op_start = 0; flag_valid = 1; flag_vec = 6'h08; tick();
        flag_vec = 6'h20; tick();
        flag_valid = 0; flag_vec = '0; tick(); tick();
        op_done = 1; tick();
        op_done = 0;
        @(negedge clk);
        lit("t1_latch", {31'd0, exc_latch}, 32'd1);
        lit("t1_exc", {26'd0, dut_exc()}, 32'h28);
        lit("t1_sup", {31'd0, sup_wb}, 32'd0);
        tick();
        @(negedge clk);
        lit("t1_busy_after", {31'd0, busy}, 32'd0);
        lit("t1_latch_after", {31'd0, exc_latch}, 32'd0);

        // Unmasked invalid pre-empts everything.
        mask_vec = 6'h3E;
        op_start = 1; tick();
        op_start = 0; flag_valid = 1; flag_vec = 6'h07; tick();
        idle_inputs(); op_done = 1; tick();
        op_done = 0;
        @(negedge clk);
        lit("t2a_exc", {26'd0, dut_exc()}, 32'h01);
        lit("t2a_sup", {31'd0, sup_wb}, 32'd1);
        tick();

        // Unmasked zero-divide beats masked denormal.
        mask_vec = 6'h3B;
        op_start = 1; tick();
        op_start = 0; flag_valid = 1; flag_vec = 6'h06; tick();
        idle_inputs(); op_done = 1; tick();
        op_done = 0;
        @(negedge clk);
        lit("t2b_exc", {26'd0, dut_exc()}, 32'h04);
        lit("t2b_sup", {31'd0, sup_wb}, 32'd1);
        tick();

        // Single-cycle op straight from IDLE.
        mask_vec = 6'h3F;
        op_start = 1; op_done = 1; flag_valid = 1; flag_vec = 6'h02; tick();
        idle_inputs();
        @(negedge clk);
        lit("t3_latch", {31'd0, exc_latch}, 32'd1);
        lit("t3_exc", {26'd0, dut_exc()}, 32'h02);
        lit("t3_sup", {31'd0, sup_wb}, 32'd0);
        tick();
        @(negedge clk);
        lit("t3_busy_after", {31'd0, busy}, 32'd0);

        // Abort wins over done; no post.
        op_start = 1; tick();
        op_start = 0; flag_valid = 1; flag_vec = 6'h3F; op_done = 1; op_abort = 1; tick();
        idle_inputs();
        @(negedge clk);
        lit("t4_abort_latch", {31'd0, exc_latch}, 32'd0);
        lit("t4_abort_busy", {31'd0, busy}, 32'd0);
        tick();
        @(negedge clk);
        lit("t4_abort_latch2", {31'd0, exc_latch}, 32'd0);

        // Start while accumulating flags a protocol error that sticks.
        op_start = 1; tick();
        tick();
        op_start = 0;
        @(negedge clk);
        lit("t4_perr", {31'd0, proto_error}, 32'd1);
        op_abort = 1; tick();
        op_abort = 0;
        @(negedge clk);
        lit("t4_perr_sticky", {31'd0, proto_error}, 32'd1);
        lit("t4_busy_idle", {31'd0, busy}, 32'd0);

        // Watchdog: no done for TMO cycles.
        mask_vec = 6'h3F;
        op_start = 1; tick();
        op_start = 0;
        found = 0; waited = 0;
        for (int i = 1; i <= TMO + 4 && !found; i++) begin
            tick();
            @(negedge clk);
            if (exc_latch) begin
                found = 1; waited = i;
            end
        end
        lit("t5_found", {31'd0, found}, 32'd1);
        lit("t5_cycles", waited, TMO);
        lit("t5_tmo_pulse", {31'd0, tmo_pulse}, 32'd1);
        lit("t5_exc", {26'd0, dut_exc()}, 32'h01);
        // Back-to-back start during the post cycle.
        op_start = 1; tick();
        op_start = 0;
        @(negedge clk);
        lit("t5_b2b_busy", {31'd0, busy}, 32'd1);
        lit("t5_b2b_latch", {31'd0, exc_latch}, 32'd0);
        op_done = 1; tick();
        op_done = 0;
        @(negedge clk);
        lit("t5_b2b_post", {31'd0, exc_latch}, 32'd1);
        lit("t5_b2b_fresh", {26'd0, dut_exc()}, 32'h00);
        tick();

        // Asynchronous reset while holding a full flag set.
        op_start = 1; flag_valid = 1; flag_vec = 6'h3F; tick();
        idle_inputs(); tick();
        #2 reset = 1'b1;
        #1;
        lit("t6_rst_busy", {31'd0, busy}, 32'd0);
        lit("t6_rst_perr", {31'd0, proto_error}, 32'd0);
        lit("t6_rst_exc", {26'd0, dut_exc()}, 32'h00);
        tick();
        reset = 1'b0;
        op_done = 1; tick();
        op_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit("t6_no_latch", {31'd0, exc_latch}, 32'd0);
            tick();
        end

        tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_exception_collector.md
Name: fpu_exception_collector

Overview:
- Upstream feeder for the FPU exception handler.
- Gathers per-cycle exception flags from the FPU execution units over the life of one instruction, then applies 8087 pre-operation priority filtering.
- At instruction completion, presents one consolidated six-bit exception set with a single-cycle latch strobe.
- Also tells the writeback stage when an unmasked pre-operation exception must suppress the result store. Includes a watchdog for operations that never complete.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed in ACCUM before the watchdog forces an invalid-operation post; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- op_start  in  1  execution unit begins an instruction
- op_done  in  1  execution unit finished the instruction
- op_abort  in  1  instruction cancelled (FINIT/flush); nothing posted
- flag_valid  in  1  flag_vec qualifier
- flag_vec  in  6  raw flags: [0]inv [1]den [2]zdiv [3]ovf [4]unf [5]prec
- mask_vec  in  6  control-word mask bits, same order; 1 = masked
- exception_invalid, exception_denormal, exception_zero_div, exception_overflow, exception_underflow, exception_precision  out  1 each  filtered flags to the handler
- exception_latch  out  1  one-cycle post strobe
- suppress_writeback  out  1  pulses with exception_latch when the result store must be cancelled
- timeout_pulse  out  1  one-cycle watchdog indication
- busy  out  1  state != IDLE
- proto_error  out  1  sticky; cleared only by reset

Behaviour:
- Reset state: state = IDLE, acc = 0, counter = 0. Every output is 0.
- All outputs are registered.
- States:
  - IDLE:
    - op_start moves to ACCUM with acc <= (flag_valid ? flag_vec : 0) and counter <= 0.
    - If op_done is also high, go straight to POST (single-cycle op).
    - op_done or op_abort without op_start is ignored.
  - ACCUM:
    - flag_valid ORs flag_vec into acc every cycle, including the op_done cycle.
    - op_done moves to POST.
    - op_abort moves to IDLE with acc cleared and no post. If op_abort and op_done are high together, abort wins.
    - op_start while in ACCUM is ignored and sets proto_error.
    - counter increments each cycle. When counter reaches TIMEOUT_CYCLES-1 without done or abort: acc[0] <= 1, timeout_pulse = 1 in the next cycle, go to POST.
  - POST (exactly one cycle):
    - Outputs carry the filtered acc, exception_latch = 1.
    - Next state is IDLE. If op_start is high in POST, go directly to ACCUM with a fresh acc (back-to-back, no bubble).
    - op_done or op_abort in POST is ignored.
- Filter, evaluated on acc at the ACCUM→POST transition using mask_vec sampled that same cycle (u = acc & ~mask_vec):
  - u[0] set: post only bit 0; suppress_writeback = 1.
  - else u[2] set: post only bit 2; suppress = 1.
  - else u[1] set: post only bit 1; suppress = 1.
  - else post acc unchanged; suppress = 0.
  - Masked flags never cause suppression.
- Latency: op_done at edge N → exception_latch high for cycle N+1 → the handler latches at edge N+2.
- Exception outputs are 0 whenever exception_latch = 0.
- Asynchronous reset mid-ACCUM: acc is discarded, no post, outputs forced to 0 immediately.

Decomposition:
- Shared package holds:
  - Bit-index constants EXC_INV=0, EXC_DEN=1, EXC_ZDIV=2, EXC_OVF=3, EXC_UNF=4, EXC_PREC=5.
  - The state encoding IDLE/ACCUM/POST.
  - The priority-filter function.
- Handler and collector both import the package.
- No sub-module; the filter is a pure function, and the counter is inline.

Test Plan:
- op_start, then flag_valid with 6'h08, then 6'h20 one cycle later, op_done at cycle 5, mask_vec = 6'h3F → one-cycle exception_latch carrying ovf+prec (6'h28), suppress = 0, busy low again at cycle 7.
- mask_vec = 6'h3E, flags 6'h07 accumulated → posted set is 6'h01 only, suppress_writeback = 1. With mask_vec = 6'h3B and flags 6'h06 → posted set is 6'h04, suppress = 1.
- op_start+op_done+flag_valid with 6'h02 in the same cycle from IDLE, mask_vec = 6'h3F → post of 6'h02 on the next cycle, no ACCUM dwell.
- op_abort in the same cycle as op_done with flags 6'h3F → no exception_latch ever, back in IDLE. Then op_start in ACCUM → proto_error = 1 and it stays 1.
- TIMEOUT_CYCLES = 8, op_start and no done → timeout_pulse and exception_latch with 6'h01 eight cycles later. Second op_start in the POST cycle → busy stays 1, new acc starts at 0.
- reset asserted mid-ACCUM holding acc = 6'h3F → all outputs 0 in the same cycle, no latch after deassert.
